div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle divide controller for the execute stage. Accepts DIV/DIVU requests from the execute stage, runs a 32-iteration restoring division, and holds the pipeline through a stall request. When done, it returns remainder/quotient as a 64-bit HI/LO value that the execute stage places on its HI/LO result path alongside MULT.

## Interface
- No parameters; width fixed at 32 bits.
- cpu_clk_50M  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- div_start  in  1  a divide is pending in the execute stage; held high while stalled.
- div_signed  in  1  1 = DIV (aluop 8'h16), 0 = DIVU (aluop 8'h17); sampled with div_start.
- div_src1  in  32  dividend; sampled on acceptance.
- div_src2  in  32  divisor; sampled on acceptance.
- div_cancel  in  1  pipeline flush; aborts any operation in progress.
- div_stall_req  out  1  stall request to the pipeline controller.
- div_ready  out  1  result valid; high for exactly one cycle.
- div_hilo  out  64  {remainder, quotient}; [63:32] goes to HI, [31:0] to LO.

## Operation
- FSM states: IDLE, BYZERO, BUSY, DONE.
- IDLE: if div_start && !div_cancel, latch operands and sign flag, then:
  - divisor == 0 → BYZERO;
  - otherwise → BUSY with count=0.
  - Latched magnitudes: absolute values when signed, raw values when unsigned.
  - Latched sign flags: quotient sign = src1[31]^src2[31]; remainder sign = src1[31]; both zero when unsigned.
- BUSY: one restoring step per cycle.
  - {rem,quo} shifted left 1; rem minus divisor.
  - If the difference is non-negative, keep it and set quo[0]=1.
  - count increments; after the step with count==31 → DONE.
- BYZERO: result = {dividend, 32'hFFFF_FFFF} (raw operands, no sign fixup) → DONE.
- DONE: div_ready=1; div_hilo = sign-corrected {rem, quo} (two's-complement negate where the flag is set) → IDLE unconditionally.
- div_stall_req = (IDLE && div_start && !div_cancel) || BUSY || BYZERO. It is combinational and low in DONE, so the pipeline advances on the ready cycle.
- div_cancel in any state forces IDLE at the next edge. It suppresses div_ready and stall_req in that same cycle.
- div_start seen in IDLE the cycle after DONE is a new instruction, so back-to-back divides are legal.
- Arithmetic:
  - Magnitudes are 32-bit unsigned; the subtract is 33-bit to expose the borrow.
  - 0x80000000 magnitude is represented exactly.
  - Signed 0x80000000 / 0xFFFFFFFF yields quo 0x80000000, rem 0 (wrap, no trap).
- div_hilo is zero outside DONE.

## Timing
- Reset (asynchronous): state=IDLE, count=0, internal regs=0. div_stall_req=0, div_ready=0, div_hilo=0.
- Reset mid-operation: immediate abort; no ready is produced.
- Normal latency: start sampled at edge N, BUSY at edges N+1..N+32, div_ready high in the cycle after edge N+33. Total is 34 cycles including the accept cycle.
- Divide by zero: div_ready high in the cycle after edge N+2.
- Operand changes after acceptance are ignored.

## Structure
- Shared package (with the existing aluop constants):
  - DIV=8'h16, DIVU=8'h17;
  - state enum {IDLE, BYZERO, BUSY, DONE} as 2-bit localparams.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- div_ctrl holds the FSM, the counter, operand/sign registers and the output fixup.

## Test plan
- DIVU 100/7: start held → stall_req high 33 cycles; ready on cycle 34; div_hilo=0x00000002_0000000E.
- DIV −7/2 (0xFFFFFFF9/0x00000002) → div_hilo=0xFFFFFFFF_FFFFFFFD.
- DIV 0x80000000/0xFFFFFFFF → 0x00000000_80000000. DIVU 0xFFFFFFFF/1 → 0x00000000_FFFFFFFF.
- DIVU 5/0 → ready 3 cycles after start, div_hilo=0x00000005_FFFFFFFF.
- div_cancel at BUSY count 10 → IDLE next cycle, no ready pulse, stall_req low.
- rst_n low at BUSY count 20 → outputs 0 immediately. Then back-to-back DIVU 9/3 and 10/4 → 0x00000000_00000003, then 0x00000002_00000002, each 34 cycles.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide controller: aluop codes, FSM states
// and small arithmetic helpers.
package div_ctrl_pkg;

  // Execute-stage aluop codes that route through the divider
  localparam logic [7:0] DIV  = 8'h16;
  localparam logic [7:0] DIVU = 8'h17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } div_state_t;

  // True for either divide opcode
  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == DIV) || (aluop == DIVU);
  endfunction

  // Two's-complement negate when the flag is set
  function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] value);
    return neg ? (32'd0 - value) : value;
  endfunction

  // Magnitude of an operand: absolute value for signed ops, raw otherwise.
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] magnitude(input logic is_signed, input logic [31:0] value);
    return (is_signed && value[31]) ? (32'd0 - value) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, try to
// subtract the divisor, keep the difference and set quo[0] if no borrow.
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] rem_shift;
  logic [32:0] diff;

  // The partial remainder stays below the divisor, so after the shift the
  // true difference lies in (-2^32, 2^32); bit 32 of the 33-bit result is
  // therefore exactly the borrow.
  assign rem_shift = {rem, quo[31]};
  assign diff      = rem_shift - {1'b0, divisor};

  // Restore on borrow, otherwise commit the difference
  always_comb begin
    rem_next = rem_shift[31:0];
    quo_next = {quo[30:0], 1'b0};
    if (!diff[32]) begin
      rem_next = diff[31:0];
      quo_next = {quo[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU controller for the execute stage. Holds the pipeline
// with a stall request while a 32-step restoring division runs, then
// presents the sign-corrected {remainder, quotient} for one cycle.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        cpu_clk_50M,
  input  logic        rst_n,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_cancel,
  output logic        div_stall_req,
  output logic        div_ready,
  output logic [63:0] div_hilo
);

  div_state_t  state_reg;
  logic [4:0]  count_reg;
  logic [31:0] rem_reg;
  logic [31:0] quo_reg;
  logic [31:0] divisor_reg;
  logic        quo_neg_reg;
  logic        rem_neg_reg;

  logic [31:0] rem_next;
  logic [31:0] quo_next;

  div_step u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (divisor_reg),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // FSM, iteration counter and operand/sign registers
  always_ff @(posedge cpu_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= 5'd0;
      rem_reg     <= 32'd0;
      quo_reg     <= 32'd0;
      divisor_reg <= 32'd0;
      quo_neg_reg <= 1'b0;
      rem_neg_reg <= 1'b0;
    end else if (div_cancel) begin
      state_reg <= IDLE;
      count_reg <= 5'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (div_start) begin
            count_reg <= 5'd0;
            if (div_src2 == 32'd0) begin
              // Raw operands pass straight through on divide-by-zero
              rem_reg     <= div_src1;
              quo_reg     <= 32'hFFFF_FFFF;
              divisor_reg <= 32'd0;
              quo_neg_reg <= 1'b0;
              rem_neg_reg <= 1'b0;
              state_reg   <= BYZERO;
            end else begin
              rem_reg     <= 32'd0;
              quo_reg     <= magnitude(div_signed, div_src1);
              divisor_reg <= magnitude(div_signed, div_src2);
              quo_neg_reg <= div_signed & (div_src1[31] ^ div_src2[31]);
              rem_neg_reg <= div_signed & div_src1[31];
              state_reg   <= BUSY;
            end
          end
        end
        BYZERO: begin
          state_reg <= DONE;
        end
        BUSY: begin
          rem_reg   <= rem_next;
          quo_reg   <= quo_next;
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            state_reg <= DONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Stall and ready decode; a flush in the same cycle suppresses both
  always_comb begin
    div_stall_req = !div_cancel &&
                    (((state_reg == IDLE) && div_start) ||
                     (state_reg == BUSY) || (state_reg == BYZERO));
    div_ready     = !div_cancel && (state_reg == DONE);
  end

  // Result fixup, visible only while the ready pulse is up
  always_comb begin
    div_hilo = 64'd0;
    if (div_ready) begin
      div_hilo = {apply_sign(rem_neg_reg, rem_reg), apply_sign(quo_neg_reg, quo_reg)};
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: latency, stall length, results, divide by
// zero, flush and asynchronous reset mid-operation.
module tb_div_ctrl;

  logic        cpu_clk_50M;
  logic        rst_n;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_cancel;
  logic        div_stall_req;
  logic        div_ready;
  logic [63:0] div_hilo;

  int total_cnt = 0;
  int bad_cnt   = 0;

  div_ctrl dut (
    .cpu_clk_50M   (cpu_clk_50M),
    .rst_n         (rst_n),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .div_src1      (div_src1),
    .div_src2      (div_src2),
    .div_cancel    (div_cancel),
    .div_stall_req (div_stall_req),
    .div_ready     (div_ready),
    .div_hilo      (div_hilo)
  );

  initial cpu_clk_50M = 1'b0;
  always #5 cpu_clk_50M = ~cpu_clk_50M;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_cnt++;
    if (observed !== expected) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%016h want 0x%016h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%016h", tag, observed);
    end
  endtask

  // Issue one divide one edge after the call, hold start until ready,
  // scramble the operands after acceptance, and check latency, stall
  // length and result.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_hilo,
                         input int exp_edges);
    int edges  = 0;
    int stalls = 0;
    @(posedge cpu_clk_50M); #1;
    div_signed = sgn;
    div_src1   = a;
    div_src2   = b;
    div_start  = 1'b1;
    #1;
    while (!div_ready && edges < 100) begin
      if (div_stall_req) stalls++;
      @(posedge cpu_clk_50M); #1;
      edges++;
      if (edges == 1) begin
        div_src1   = $urandom;
        div_src2   = $urandom;
        div_signed = ~sgn;
      end
    end
    check({tag, " edges"}, 64'(edges), 64'(exp_edges));
    check({tag, " stalls"}, 64'(stalls), 64'(exp_edges));
    check({tag, " stall_in_done"}, {63'd0, div_stall_req}, 64'd0);
    check({tag, " hilo"}, div_hilo, exp_hilo);
    div_start = 1'b0;
  endtask

  initial begin
    int seen;
    rst_n      = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_src1   = 32'd0;
    div_src2   = 32'd0;
    div_cancel = 1'b0;
    #12;
    check("reset stall", {63'd0, div_stall_req}, 64'd0);
    check("reset ready", {63'd0, div_ready}, 64'd0);
    check("reset hilo", div_hilo, 64'd0);
    @(negedge cpu_clk_50M);
    rst_n = 1'b1;

    run_div("divu 100/7",      1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33);
    @(posedge cpu_clk_50M); #1;
    check("ready one cycle", {63'd0, div_ready}, 64'd0);
    check("hilo after done", div_hilo, 64'd0);
    run_div("div -7/2",        1'b1, 32'hFFFF_FFF9, 32'd2,         64'hFFFFFFFF_FFFFFFFD, 33);
    run_div("div 7/-2",        1'b1, 32'd7,         32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33);
    run_div("div min/-1",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33);
    run_div("divu max/1",      1'b0, 32'hFFFF_FFFF, 32'd1,         64'h00000000_FFFFFFFF, 33);
    run_div("divu 5/0",        1'b0, 32'd5,         32'd0,         64'h00000005_FFFFFFFF, 2);
    run_div("div -7/0",        1'b1, 32'hFFFF_FFF9, 32'd0,         64'hFFFFFFF9_FFFFFFFF, 2);

    // Flush while BUSY with count 10
    @(posedge cpu_clk_50M); #1;
    div_signed = 1'b0; div_src1 = 32'd1000; div_src2 = 32'd3; div_start = 1'b1;
    repeat (11) @(posedge cpu_clk_50M);
    #1;
    check("cancel pre stall", {63'd0, div_stall_req}, 64'd1);
    div_cancel = 1'b1;
    div_start  = 1'b0;
    #1;
    check("cancel same-cycle stall", {63'd0, div_stall_req}, 64'd0);
    check("cancel same-cycle ready", {63'd0, div_ready}, 64'd0);
    @(posedge cpu_clk_50M); #1;
    div_cancel = 1'b0;
    #1;
    check("cancel idle stall", {63'd0, div_stall_req}, 64'd0);
    seen = 0;
    repeat (30) begin
      @(posedge cpu_clk_50M); #1;
      if (div_ready || div_stall_req) seen++;
    end
    check("cancel no ready", 64'(seen), 64'd0);

    // Asynchronous reset while BUSY with count 20
    @(posedge cpu_clk_50M); #1;
    div_signed = 1'b0; div_src1 = 32'd50; div_src2 = 32'd5; div_start = 1'b1;
    repeat (21) @(posedge cpu_clk_50M);
    #1;
    rst_n     = 1'b0;
    div_start = 1'b0;
    #1;
    check("rst stall", {63'd0, div_stall_req}, 64'd0);
    check("rst ready", {63'd0, div_ready}, 64'd0);
    check("rst hilo", div_hilo, 64'd0);
    @(negedge cpu_clk_50M);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge cpu_clk_50M); #1;
      if (div_ready) seen++;
    end
    check("rst no ready", 64'(seen), 64'd0);

    // Back-to-back divides: second start lands on the IDLE cycle after DONE
    run_div("divu 9/3",  1'b0, 32'd9,  32'd3, 64'h00000000_00000003, 33);
    run_div("divu 10/4", 1'b0, 32'd10, 32'd4, 64'h00000002_00000002, 33);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
